instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory.
- Accepts a program as a valid/ready byte stream (from the boot/UART path) and packs each 4 bytes into a 32-bit word.
- Issues one word write per 4 bytes to the memory write port and verifies a trailing 8-bit checksum.
- Holds the core in reset (Core_Hold) until a load completes cleanly.

Parameters:
MEM_BYTES, 96, instruction memory capacity in bytes (multiple of 4)
BASE_ADDR, 0, byte address of first written word
CNT_W, 16, width of Word_Count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
Start  input  1  begin a load; sampled only in IDLE, DONE, ERR
Word_Count  input  CNT_W  number of 32-bit words to load; latched on accepted Start
Byte_In  input  8  stream data
Byte_Valid  input  1  Byte_In valid
Byte_Ready  output  1  loader accepts Byte_In this cycle
Wr_En  output  1  memory write strobe, one cycle per word
Wr_Addr  output  64  byte address of word (4-aligned)
Wr_Data  output  32  {byte3,byte2,byte1,byte0}; byte0 = first received
Core_Hold  output  1  keep core stalled/in reset
Busy  output  1  load in progress (RECV, WRITE, CHECK)
Done  output  1  level, high in DONE
Error  output  1  level, high in ERR

Behaviour:
- Reset (async, reset=0): state IDLE.
  - Byte_Ready=0, Wr_En=0, Wr_Addr=BASE_ADDR, Wr_Data=0, Core_Hold=1, Busy=0, Done=0, Error=0.
  - Word index, byte lane counter and checksum accumulator are cleared.
  - Reset mid-load abandons the load; memory keeps any words already written.
- Byte transfer occurs only on a cycle where Byte_Valid && Byte_Ready. Byte_Valid without Byte_Ready is not consumed.
- States:
  - IDLE/DONE/ERR + Start:
    - If Word_Count==0 or Word_Count*4 > MEM_BYTES: go to ERR, no writes.
    - Else: latch Word_Count, clear counters and checksum, Core_Hold=1, go to RECV.
  - RECV: Byte_Ready=1.
    - Each accepted byte goes to lane[cnt] (cnt 0..3), and checksum += byte (mod 256).
    - On the 4th byte, go to WRITE.
  - WRITE (exactly 1 cycle): Byte_Ready=0, Wr_En=1, Wr_Addr=BASE_ADDR+4*word_idx, Wr_Data=packed word.
    - Then word_idx++.
    - If word_idx+1 == Word_Count go to CHECK, else back to RECV.
  - CHECK: Byte_Ready=1.
    - Accepted byte == checksum: go to DONE, Core_Hold=0.
    - Otherwise: go to ERR, Core_Hold stays 1.
  - DONE: Done=1, Core_Hold=0. Stays until Start or reset.
  - ERR: Error=1, Core_Hold=1. Stays until Start or reset.
- Latency: 4th byte accepted in cycle N gives Wr_En in cycle N+1. RECV resumes in cycle N+2.
- Start while Busy is ignored, and Word_Count changes while Busy are ignored.
- Wr_Addr/Wr_Data hold their last values when Wr_En=0.
- Wr_Addr never exceeds BASE_ADDR+MEM_BYTES-4; the range check on Start guarantees this.
- Arithmetic: checksum is 8-bit wrap. Word_Count*4 is compared at CNT_W+2 bits, so there is no overflow.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RECV, WRITE, CHECK, DONE, ERR);
  - constants WORD_BYTES=4 and CHK_W=8;
  - default MEM_BYTES.
- One sub-module, word_packer: 2-bit lane counter, four byte registers, word_full flag, clear input. The FSM and checksum stay in instr_mem_loader.

Test Plan:
- Load 4 words, bytes 93 00 50 00 13 01 10 00 B3 81 00 00 B3 02 11 00, checksum 01.
  - Writes (0,0x00500093), (4,0x00100113), (8,0x000081B3), (12,0x001102B3).
  - Done=1, Core_Hold=0.
- Same stream with checksum 02 -> four writes occur, then Error=1, Core_Hold=1, Done=0.
- Start with Word_Count=0, and Start with Word_Count=25 (100>96) -> ERR next cycle, no Wr_En ever.
- Byte_Valid toggled 1/0 randomly during load -> identical writes/addresses. Byte_Ready=0 exactly in WRITE cycles, and no byte is lost or duplicated.
- Assert reset after 6 bytes of a 4-word load -> immediately IDLE with all reset values.
  - A subsequent Start and full load then succeeds with correct addresses from BASE_ADDR.
- Word_Count=24 (full 96 bytes) -> last write at Wr_Addr=92. Start pulsed mid-load is ignored. DONE is reached with a correct checksum.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding, word/checksum geometry and the default memory size.
package instr_mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   localparam int WORD_BYTES    = 4;
   localparam int LANE_W        = $clog2(WORD_BYTES);
   localparam int CHK_W         = 8;
   localparam int DEF_MEM_BYTES = 96;

   // A new load may only begin from a resting state.
   function automatic logic can_start(input state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
   endfunction

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Collects accepted bytes into a little-endian 32-bit word; word_full flags the
// byte that completes the word. Zero latency on word_full, no backpressure of its own.
module word_packer
   import instr_mem_loader_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic [7:0]                byte_dat,
   output logic [8*WORD_BYTES-1:0]   word,
   output logic                      word_full
);

   logic [LANE_W-1:0] lane;
   logic [7:0]        lanes [WORD_BYTES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane <= '0;
         for (int i = 0; i < WORD_BYTES; i++) lanes[i] <= '0;
      end else if (clear) begin
         lane <= '0;
         for (int i = 0; i < WORD_BYTES; i++) lanes[i] <= '0;
      end else if (push) begin
         lanes[lane] <= byte_dat;
         lane        <= lane + LANE_W'(1);
      end
   end

   always_comb begin
      word = '0;
      for (int i = 0; i < WORD_BYTES; i++) word[8*i +: 8] = lanes[i];
   end

   assign word_full = push && (lane == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program into instruction memory one word per 4 bytes, then checks a trailing sum.
// Write strobe one cycle after the 4th byte; Byte_Ready drops during the write cycle.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int          MEM_BYTES = DEF_MEM_BYTES,
   parameter logic [63:0] BASE_ADDR = 64'd0,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [CNT_W-1:0] Word_Count,
   input  logic [7:0]       Byte_In,
   input  logic             Byte_Valid,
   output logic             Byte_Ready,
   output logic             Wr_En,
   output logic [63:0]      Wr_Addr,
   output logic [31:0]      Wr_Data,
   output logic             Core_Hold,
   output logic             Busy,
   output logic             Done,
   output logic             Error
);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   word_idx;
   logic [CNT_W-1:0]   word_cnt;
   logic [CHK_W-1:0]   chk;
   logic [63:0]        addr_hold;
   logic [31:0]        data_hold;
   logic [31:0]        pack_word;
   logic               word_full;
   logic [CNT_W+1:0]   req_bytes;
   logic               count_bad;
   logic               start_go;
   logic               push;
   logic               last_word;
   logic [63:0]        cur_addr;

   // Extra two bits keep Word_Count*4 from wrapping before the capacity compare.
   assign req_bytes = {Word_Count, 2'b00};
   assign count_bad = (Word_Count == '0) || (req_bytes > (CNT_W+2)'(MEM_BYTES));
   assign start_go  = Start && can_start(state) && !count_bad;
   assign push      = Byte_Valid && (state == ST_RECV);
   assign last_word = (word_idx + CNT_W'(1)) == word_cnt;
   assign cur_addr  = BASE_ADDR + (64'(word_idx) << 2);

   word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_go),
      .push      (push),
      .byte_dat  (Byte_In),
      .word      (pack_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (Start) state_nxt = count_bad ? ST_ERR : ST_RECV;
         end
         ST_RECV: begin
            if (word_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            state_nxt = last_word ? ST_CHECK : ST_RECV;
         end
         ST_CHECK: begin
            if (Byte_Valid) state_nxt = (Byte_In == chk) ? ST_DONE : ST_ERR;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      Byte_Ready = 1'b0;
      Wr_En      = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      Error      = 1'b0;
      Core_Hold  = 1'b1;
      unique case (state)
         ST_RECV:  begin Byte_Ready = 1'b1; Busy = 1'b1; end
         ST_WRITE: begin Wr_En = 1'b1; Busy = 1'b1; end
         ST_CHECK: begin Byte_Ready = 1'b1; Busy = 1'b1; end
         ST_DONE:  begin Done = 1'b1; Core_Hold = 1'b0; end
         ST_ERR:   Error = 1'b1;
         default:  ;
      endcase
   end

   // Address/data are live in the write cycle and held from registers otherwise.
   assign Wr_Addr = (state == ST_WRITE) ? cur_addr  : addr_hold;
   assign Wr_Data = (state == ST_WRITE) ? pack_word : data_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_idx  <= '0;
         word_cnt  <= '0;
         chk       <= '0;
         addr_hold <= BASE_ADDR;
         data_hold <= '0;
      end else begin
         if (start_go) begin
            word_cnt <= Word_Count;
            word_idx <= '0;
            chk      <= '0;
         end
         if (push) chk <= chk + Byte_In;
         if (state == ST_WRITE) begin
            word_idx  <= word_idx + CNT_W'(1);
            addr_hold <= cur_addr;
            data_hold <= pack_word;
         end
      end
   end

endmodule
